fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised result-tracking and forwarding block for the N-issue SPU pipeline, successor to the fixed two-pipe, seven-stage forwarding unit. It holds a DEPTH-stage shift register of in-flight results per issue pipe and captures each result at its per-instruction latency stage. It returns, for every source operand, the youngest ready in-flight value or the register-file value, and raises a stall on a not-ready operand or a completion-port conflict. It sits between register-file read and the execution pipes and drives the write-back port at the final stage.

## Interface
- NUM_PIPES, 2, issue pipes (pipe index = program order within a bundle; higher is younger)
- NUM_SRC, 3, source operands per pipe
- DEPTH, 7, tracked stages per pipe (≥3)
- DATA_W, 128, value width
- ADDR_W, 7, register address width
- LAT_W, 3, latency/stage field width (2^LAT_W > DEPTH)

Ports, all vectors flattened with pipe p / source k at slice p (or p*NUM_SRC+k):
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- issue_valid  in  NUM_PIPES  instruction presented this cycle
- issue_wr  in  NUM_PIPES  instruction writes rt
- issue_rt  in  NUM_PIPES*ADDR_W  destination address
- issue_lat  in  NUM_PIPES*LAT_W  stage at which the pipe delivers the result (legal 1..DEPTH-1)
- src_addr  in  NUM_PIPES*NUM_SRC*ADDR_W  source addresses
- rf_value  in  NUM_PIPES*NUM_SRC*DATA_W  register-file read data for each source
- res_value  in  NUM_PIPES*DATA_W  result delivered by pipe p this cycle
- flush_valid  in  1  branch flush
- flush_stage  in  LAT_W  entries at stages below this are killed
- src_value  out  NUM_PIPES*NUM_SRC*DATA_W  forwarded operand
- stall  out  1  issue bundle not accepted this cycle
- wb_valid  out  NUM_PIPES  write-back enable from stage DEPTH
- wb_rt  out  NUM_PIPES*ADDR_W  write-back address
- wb_value  out  NUM_PIPES*DATA_W  write-back data

## Operation
- Entry per pipe per stage: valid, wr, rt, lat, value, done. Stage 1 holds the instruction accepted in the previous cycle; every edge moves stage s to s+1; stage DEPTH is presented on wb_* and then discarded.
- Illegal issue_lat (0 or ≥DEPTH) is clamped to DEPTH-1.
- Capture: at most one entry per pipe has stage == lat. On the edge it leaves that stage, res_value[p] is written into it and done is set.
- Lookup per source: candidates are valid, wr=1 entries of all pipes with rt == src_addr. Smallest stage wins; on equal stage, the higher pipe index wins. If the winner is done, src_value = its value. If it is not done, stall=1. With no candidate, src_value = rf_value. Lookup ignores instructions in the same bundle.
- Completion conflict: an issue in pipe p with latency L stalls if any valid entry of pipe p at stage s has lat − s == L.
- stall = OR of all not-ready conditions and conflicts over valid issues. While stalled, no issue_valid is inserted, so stage 1 gets bubbles in every pipe. In-flight entries still advance.
- Flush: when flush_valid=1, entries entering stages below flush_stage+1 (currently at stages < flush_stage) are invalidated on the edge, and that cycle's issues are dropped. Flush has priority over issue and capture.
- Write-back: wb_valid[p] = valid & wr & done of stage DEPTH; wb_rt and wb_value come from that entry.

## Timing
- Reset: all entries invalid. wb_valid=0, wb_rt=0, wb_value=0, and stall=0 with no issue. src_value = rf_value from the cycle after reset.
- src_value and stall are combinational from inputs and registered state (same cycle). wb_* are registered state only.
- Issue accepted in cycle t: stage 1 at t+1, result sampled at cycle t+lat, forwardable from t+lat+1, write-back presented at cycle t+DEPTH.
- A dependent source at cycle t+1..t+lat gets stall=1. At cycle ≥t+lat+1 it gets the captured value.
- Reset asserted mid-operation clears all entries on that edge. No write-back is produced for them.

## Test plan
- Reset held 2 cycles, then idle with rf_value=0x11…11 → wb_valid=0, stall=0, src_value=0x11…11.
- Pipe0 issues rt=5, lat=2, wr=1 at t. Res_value=0xA5…A5 at t+2. Pipe1 src rt=5 → stall=1 at t+1 and t+2, src_value=0xA5…A5 at t+3.
- Pipe0 rt=9 issued at t (value 0x1), pipe1 rt=9 issued at t+1 (value 0x2), both lat=1. At t+3 the lookup of rt=9 → 0x2.
- Pipe0 entry with lat=4 at stage 2. Pipe0 issue with lat=2 → stall=1 and no stage-1 insert. The same issue with lat=3 → accepted.
- Entries at stages 1, 2, 3 with rt=7. flush_valid=1, flush_stage=3 → only the stage-3 entry survives (now at stage 4). Lookup rt=7 returns its value. A fully flushed rt falls back to rf_value.
- DEPTH=7, lat=3 issue at t, rt=12 → wb_valid=1, wb_rt=12, wb_value = captured result at t+7 only. With wr=0 → wb_valid stays 0.

Source files
------------

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard
// Brief    : Parametrised in-flight result tracker and operand forwarder for
//            an N-issue pipeline. Each issue pipe owns a DEPTH-stage shift
//            register of entries; results are captured at their latency
//            stage, forwarded to younger consumers and written back when the
//            entry reaches the final stage.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_scoreboard #(
  parameter int NUM_PIPES = 2,
  parameter int NUM_SRC   = 3,
  parameter int DEPTH     = 7,
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 7,
  parameter int LAT_W     = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_PIPES-1:0]                issue_valid,
  input  logic [NUM_PIPES-1:0]                issue_wr,
  input  logic [NUM_PIPES*ADDR_W-1:0]         issue_rt,
  input  logic [NUM_PIPES*LAT_W-1:0]          issue_lat,
  input  logic [NUM_PIPES*NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_PIPES*NUM_SRC*DATA_W-1:0] rf_value,
  input  logic [NUM_PIPES*DATA_W-1:0]         res_value,
  input  logic                                flush_valid,
  input  logic [LAT_W-1:0]                    flush_stage,
  output logic [NUM_PIPES*NUM_SRC*DATA_W-1:0] src_value,
  output logic                                stall,
  output logic [NUM_PIPES-1:0]                wb_valid,
  output logic [NUM_PIPES*ADDR_W-1:0]         wb_rt,
  output logic [NUM_PIPES*DATA_W-1:0]         wb_value
);

  // Per-pipe, per-stage entry fields. Stage index 1 is the youngest slot.
  logic              st_valid [NUM_PIPES][1:DEPTH];
  logic              st_wr    [NUM_PIPES][1:DEPTH];
  logic              st_done  [NUM_PIPES][1:DEPTH];
  logic [ADDR_W-1:0] st_rt    [NUM_PIPES][1:DEPTH];
  logic [LAT_W-1:0]  st_lat   [NUM_PIPES][1:DEPTH];
  logic [DATA_W-1:0] st_value [NUM_PIPES][1:DEPTH];

  // Out-of-range latencies fall back to the last capturable stage.
  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] l);
    if ((l == '0) || (int'(l) >= DEPTH)) begin
      return LAT_W'(DEPTH - 1);
    end
    return l;
  endfunction

  // Operand lookup (youngest in-flight producer wins) and stall generation.
  always_comb begin
    logic              hit;
    logic              hit_done;
    logic [DATA_W-1:0] hit_val;
    logic [LAT_W-1:0]  lat_c;
    int                idx;
    src_value = '0;
    stall     = 1'b0;
    hit       = 1'b0;
    hit_done  = 1'b0;
    hit_val   = '0;
    lat_c     = '0;
    idx       = 0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        idx      = p * NUM_SRC + k;
        hit      = 1'b0;
        hit_done = 1'b0;
        hit_val  = '0;
        // Scan oldest to youngest so the last match is the smallest stage,
        // and on a stage tie the highest (youngest) pipe.
        for (int s = DEPTH; s >= 1; s--) begin
          for (int q = 0; q < NUM_PIPES; q++) begin
            if (st_valid[q][s] && st_wr[q][s] &&
                (st_rt[q][s] == src_addr[idx*ADDR_W +: ADDR_W])) begin
              hit      = 1'b1;
              hit_done = st_done[q][s];
              hit_val  = st_value[q][s];
            end
          end
        end
        src_value[idx*DATA_W +: DATA_W] = hit ? hit_val : rf_value[idx*DATA_W +: DATA_W];
        if (issue_valid[p] && hit && !hit_done) begin
          stall = 1'b1;
        end
      end
      // A new issue must not complete in the same cycle as an older entry
      // of its own pipe, since each pipe has a single result port.
      lat_c = clamp_lat(issue_lat[p*LAT_W +: LAT_W]);
      if (issue_valid[p]) begin
        for (int s = 1; s <= DEPTH; s++) begin
          if (st_valid[p][s] && ((int'(st_lat[p][s]) - s) == int'(lat_c))) begin
            stall = 1'b1;
          end
        end
      end
    end
  end

  // Advance every pipe by one stage: capture, flush kill and issue insert.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        for (int s = 1; s <= DEPTH; s++) begin
          st_valid[p][s] <= 1'b0;
          st_wr[p][s]    <= 1'b0;
          st_done[p][s]  <= 1'b0;
          st_rt[p][s]    <= '0;
          st_lat[p][s]   <= '0;
          st_value[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        for (int s = DEPTH; s >= 2; s--) begin
          if (flush_valid && ((s - 1) < int'(flush_stage))) begin
            st_valid[p][s] <= 1'b0;
            st_wr[p][s]    <= 1'b0;
            st_done[p][s]  <= 1'b0;
            st_rt[p][s]    <= '0;
            st_lat[p][s]   <= '0;
            st_value[p][s] <= '0;
          end else begin
            st_valid[p][s] <= st_valid[p][s-1];
            st_wr[p][s]    <= st_wr[p][s-1];
            st_rt[p][s]    <= st_rt[p][s-1];
            st_lat[p][s]   <= st_lat[p][s-1];
            // The entry leaving its latency stage takes this cycle's result.
            if (st_valid[p][s-1] && (int'(st_lat[p][s-1]) == (s - 1))) begin
              st_done[p][s]  <= 1'b1;
              st_value[p][s] <= res_value[p*DATA_W +: DATA_W];
            end else begin
              st_done[p][s]  <= st_done[p][s-1];
              st_value[p][s] <= st_value[p][s-1];
            end
          end
        end
        if (issue_valid[p] && !stall && !flush_valid) begin
          st_valid[p][1] <= 1'b1;
          st_wr[p][1]    <= issue_wr[p];
          st_rt[p][1]    <= issue_rt[p*ADDR_W +: ADDR_W];
          st_lat[p][1]   <= clamp_lat(issue_lat[p*LAT_W +: LAT_W]);
        end else begin
          st_valid[p][1] <= 1'b0;
          st_wr[p][1]    <= 1'b0;
          st_rt[p][1]    <= '0;
          st_lat[p][1]   <= '0;
        end
        st_done[p][1]  <= 1'b0;
        st_value[p][1] <= '0;
      end
    end
  end

  // Write-back is driven straight from the final stage of each pipe.
  generate
    for (genvar gp = 0; gp < NUM_PIPES; gp++) begin : g_wb
      assign wb_valid[gp]                     = st_valid[gp][DEPTH] & st_wr[gp][DEPTH] & st_done[gp][DEPTH];
      assign wb_rt[gp*ADDR_W +: ADDR_W]       = st_rt[gp][DEPTH];
      assign wb_value[gp*DATA_W +: DATA_W]    = st_value[gp][DEPTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fwd_scoreboard
// Brief    : Directed self-checking bench for fwd_scoreboard with a
//            write-back scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;
  localparam int NP = 2;
  localparam int NS = 3;
  localparam int D  = 7;
  localparam int DW = 128;
  localparam int AW = 7;
  localparam int LW = 3;

  localparam logic [DW-1:0] RF  = {16{8'h11}};
  localparam logic [DW-1:0] VA5 = {16{8'hA5}};

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NP-1:0]        issue_valid;
  logic [NP-1:0]        issue_wr;
  logic [NP*AW-1:0]     issue_rt;
  logic [NP*LW-1:0]     issue_lat;
  logic [NP*NS*AW-1:0]  src_addr;
  logic [NP*NS*DW-1:0]  rf_value;
  logic [NP*DW-1:0]     res_value;
  logic                 flush_valid;
  logic [LW-1:0]        flush_stage;
  logic [NP*NS*DW-1:0]  src_value;
  logic                 stall;
  logic [NP-1:0]        wb_valid;
  logic [NP*AW-1:0]     wb_rt;
  logic [NP*DW-1:0]     wb_value;

  fwd_scoreboard #(
    .NUM_PIPES(NP), .NUM_SRC(NS), .DEPTH(D), .DATA_W(DW), .ADDR_W(AW), .LAT_W(LW)
  ) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rt(issue_rt), .issue_lat(issue_lat),
    .src_addr(src_addr), .rf_value(rf_value), .res_value(res_value),
    .flush_valid(flush_valid), .flush_stage(flush_stage),
    .src_value(src_value), .stall(stall),
    .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_value(wb_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    int              pipe;
    int              due;
    logic [AW-1:0]   rt;
    logic [DW-1:0]   val;
  } wb_t;

  wb_t exp_q[$];
  int  cycle  = 0;
  int  passed = 0;
  int  failed = 0;
  int  total  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wb(input int p, input int rt, input logic [DW-1:0] v);
    wb_t e;
    e.pipe = p;
    e.due  = cycle + D;
    e.rt   = AW'(rt);
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and score the write-back port against the queue.
  task automatic tick();
    @(posedge clock);
    #1;
    cycle++;
    for (int p = 0; p < NP; p++) begin
      int hit;
      hit = -1;
      foreach (exp_q[i]) begin
        if (hit < 0 && exp_q[i].pipe == p && exp_q[i].due == cycle) hit = i;
      end
      if (hit >= 0) begin
        chk("wb_valid", DW'(wb_valid[p]), DW'(1));
        chk("wb_rt", DW'(wb_rt[p*AW +: AW]), DW'(exp_q[hit].rt));
        chk("wb_value", wb_value[p*DW +: DW], exp_q[hit].val);
        exp_q.delete(hit);
      end else begin
        chk("wb_idle", DW'(wb_valid[p]), DW'(0));
      end
    end
  endtask

  task automatic set_issue(input int p, input bit v, input bit wr, input int rt, input int lat);
    issue_valid[p]         = v;
    issue_wr[p]            = wr;
    issue_rt[p*AW +: AW]   = AW'(rt);
    issue_lat[p*LW +: LW]  = LW'(lat);
  endtask

  task automatic set_src(input int p, input int k, input int a);
    src_addr[(p*NS+k)*AW +: AW] = AW'(a);
  endtask

  task automatic set_res(input int p, input logic [DW-1:0] v);
    res_value[p*DW +: DW] = v;
  endtask

  function automatic logic [DW-1:0] srcv(input int p, input int k);
    return src_value[(p*NS+k)*DW +: DW];
  endfunction

  task automatic clear_all();
    issue_valid = '0;
    issue_wr    = '0;
    issue_rt    = '0;
    issue_lat   = '0;
    src_addr    = '0;
    res_value   = '0;
    flush_valid = 1'b0;
    flush_stage = '0;
  endtask

  task automatic idle(input int n);
    clear_all();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clear_all();
    rf_value = {(NP*NS){RF}};

    // Reset held two cycles, then one idle cycle.
    tick();
    tick();
    reset = 1'b0;
    tick();
    #1;
    chk("reset_stall", DW'(stall), DW'(0));
    chk("reset_src00", srcv(0, 0), RF);
    chk("reset_src12", srcv(1, 2), RF);

    // Dependent consumer stalls until the producer's result is captured.
    set_issue(0, 1, 1, 5, 2);
    #1;
    chk("raw_issue_stall", DW'(stall), DW'(0));
    push_wb(0, 5, VA5);
    tick();
    set_issue(0, 0, 0, 0, 0);
    set_issue(1, 1, 0, 20, 1);
    set_src(1, 0, 5);
    #1;
    chk("raw_stall_t1", DW'(stall), DW'(1));
    tick();
    set_res(0, VA5);
    #1;
    chk("raw_stall_t2", DW'(stall), DW'(1));
    tick();
    set_res(0, '0);
    #1;
    chk("raw_stall_t3", DW'(stall), DW'(0));
    chk("raw_fwd_t3", srcv(1, 0), VA5);
    tick();
    idle(8);

    // Two producers of rt=9 in consecutive cycles: the younger one wins.
    set_issue(0, 1, 1, 9, 1);
    push_wb(0, 9, DW'(1));
    tick();
    set_issue(0, 0, 0, 0, 0);
    set_res(0, DW'(1));
    set_issue(1, 1, 1, 9, 1);
    push_wb(1, 9, DW'(2));
    tick();
    set_issue(1, 0, 0, 0, 0);
    set_res(0, '0);
    set_res(1, DW'(2));
    set_issue(0, 1, 0, 0, 1);
    set_src(0, 1, 9);
    #1;
    chk("young_notready_stall", DW'(stall), DW'(1));
    tick();
    set_res(1, '0);
    #1;
    chk("young_ready_stall", DW'(stall), DW'(0));
    chk("young_fwd", srcv(0, 1), DW'(2));
    tick();
    idle(8);

    // Same-bundle producers at equal stage: higher pipe wins.
    set_issue(0, 1, 1, 13, 1);
    set_issue(1, 1, 1, 13, 1);
    push_wb(0, 13, DW'(3));
    push_wb(1, 13, DW'(4));
    tick();
    clear_all();
    set_res(0, DW'(3));
    set_res(1, DW'(4));
    tick();
    set_res(0, '0);
    set_res(1, '0);
    set_src(1, 2, 13);
    #1;
    chk("tie_high_pipe", srcv(1, 2), DW'(4));
    idle(8);

    // Completion-port conflict in pipe 0.
    set_issue(0, 1, 1, 20, 4);
    push_wb(0, 20, {16{8'hB2}});
    tick();
    set_issue(0, 0, 0, 0, 0);
    tick();
    set_issue(0, 1, 1, 21, 2);
    #1;
    chk("conflict_stall", DW'(stall), DW'(1));
    tick();
    set_issue(0, 1, 1, 22, 3);
    #1;
    chk("conflict_free", DW'(stall), DW'(0));
    push_wb(0, 22, {16{8'hC3}});
    tick();
    set_issue(0, 0, 0, 0, 0);
    set_res(0, {16{8'hB2}});
    tick();
    set_res(0, '0);
    tick();
    set_res(0, {16{8'hC3}});
    tick();
    set_res(0, '0);
    idle(9);

    // Flush kills stages below flush_stage; older entry survives.
    set_issue(0, 1, 1, 7, 1);
    push_wb(0, 7, {16{8'h5E}});
    tick();
    set_issue(0, 1, 1, 7, 5);
    set_res(0, {16{8'h5E}});
    set_issue(1, 1, 1, 8, 1);
    tick();
    set_issue(0, 1, 1, 7, 5);
    set_issue(1, 0, 0, 0, 0);
    set_res(0, '0);
    set_res(1, {16{8'h77}});
    tick();
    set_issue(0, 0, 0, 0, 0);
    set_res(1, '0);
    set_issue(1, 1, 1, 8, 1);
    flush_valid = 1'b1;
    flush_stage = 3'd3;
    tick();
    clear_all();
    set_src(0, 0, 7);
    set_src(1, 0, 8);
    #1;
    chk("flush_survivor", srcv(0, 0), {16{8'h5E}});
    chk("flush_rf_fallback", srcv(1, 0), RF);
    idle(9);

    // Write-back only for the wr=1 instruction, exactly DEPTH cycles later.
    set_issue(0, 1, 1, 12, 3);
    set_issue(1, 1, 0, 14, 3);
    push_wb(0, 12, {16{8'hD4}});
    tick();
    clear_all();
    tick();
    tick();
    set_res(0, {16{8'hD4}});
    set_res(1, {16{8'hEE}});
    tick();
    idle(9);

    // Reset mid-operation discards in-flight entries.
    set_issue(0, 1, 1, 30, 1);
    tick();
    clear_all();
    set_res(0, {16{8'hE5}});
    tick();
    set_res(0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_src(0, 0, 30);
    #1;
    chk("reset_mid_src", srcv(0, 0), RF);
    idle(9);

    chk("wb_queue_empty", DW'(exp_q.size()), DW'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
